// File: rtl/kgp_fetch_pkg.sv
// Shared definitions for the KGP-RISC fetch stage: state encodings, PC step,
// and branch-target formation (also used by the branch unit).
package kgp_fetch_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_HALT  = 3'd3,
        S_ERR   = 3'd4
    } fetch_state_e;

    localparam logic [31:0] PC_STEP = 32'd4;

    // Instruction slot presented to decode.
    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_slot_t;

    function automatic logic [31:0] branch_target(input logic [25:0] off);
        return {4'b0, off, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Counts consecutive un-acked fetch cycles; expired flags the last allowed cycle
// so the sequencer can move to ERR on the edge that ends it.
module fetch_timeout_ctr #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + CW'(1);
    end

    assign expired = (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, fetches over imem req/ack, hands
// instructions to decode, and handles redirect, halt and memory timeout.
module fetch_sequencer
    import kgp_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'd0,
    parameter int          IMEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        stall,
    input  logic        redirect,
    input  logic [25:0] redirect_offset,
    input  logic        halt,
    output logic        halted,
    output logic        fetch_err
);

    fetch_state_e state;
    fetch_slot_t  slot;
    logic [31:0]  pc;
    logic         halt_pending;
    logic         in_fetch;
    logic         redir_ok;
    logic         stop_req;
    logic         expired;

    assign in_fetch  = (state == S_FETCH);
    assign redir_ok  = redirect && (state == S_FETCH || state == S_ISSUE);
    assign stop_req  = halt || halt_pending;

    assign imem_req    = in_fetch;
    assign imem_addr   = pc;
    assign instr_valid = slot.valid;
    assign instr       = slot.instr;
    assign instr_pc    = slot.pc;

    // Held at zero outside FETCH, so every FETCH entry (including a
    // redirected refetch) starts a fresh wait window.
    fetch_timeout_ctr #(.LIMIT(IMEM_TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (!in_fetch || redir_ok),
        .en      (in_fetch && !imem_ack),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            pc           <= RESET_PC;
            slot         <= '0;
            halt_pending <= 1'b0;
            halted       <= 1'b0;
            fetch_err    <= 1'b0;
        end else begin
            if (halt)
                halt_pending <= 1'b1;
            case (state)
                S_IDLE: state <= S_FETCH;
                S_FETCH: begin
                    if (redir_ok) begin
                        // Any same-cycle ack data belongs to the old path; drop it.
                        pc         <= branch_target(redirect_offset);
                        slot.valid <= 1'b0;
                        if (stop_req) begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end else begin
                            state <= S_FETCH;
                        end
                    end else if (stop_req) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else if (imem_ack) begin
                        slot  <= '{valid: 1'b1, instr: imem_data, pc: pc};
                        pc    <= pc + PC_STEP;
                        state <= S_ISSUE;
                    end else if (expired) begin
                        state     <= S_ERR;
                        fetch_err <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (redir_ok) begin
                        pc         <= branch_target(redirect_offset);
                        slot.valid <= 1'b0;
                        if (stop_req) begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end else begin
                            state <= S_FETCH;
                        end
                    end else if (!stall) begin
                        slot.valid <= 1'b0;
                        if (stop_req) begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                default: ;  // HALT and ERR are left only through rst
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: cycle table for fetch/stall/redirect/timeout,
// then hand sequences for reset, PC wrap and halt corners.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        stall;
    logic        redirect;
    logic [25:0] redirect_offset;
    logic        halt;

    logic        req1, v1, halted1, err1;
    logic [31:0] addr1, instr1, ipc1;
    logic        req2, v2, halted2, err2;
    logic [31:0] addr2, instr2, ipc2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(.RESET_PC(32'd0), .IMEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .imem_req(req1), .imem_addr(addr1),
        .imem_ack(imem_ack), .imem_data(imem_data), .instr_valid(v1),
        .instr(instr1), .instr_pc(ipc1), .stall(stall), .redirect(redirect),
        .redirect_offset(redirect_offset), .halt(halt), .halted(halted1),
        .fetch_err(err1)
    );

    // Second instance starts at the top of the address space for the wrap check.
    fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC), .IMEM_TIMEOUT(15)) dut_wrap (
        .clk(clk), .rst(rst), .imem_req(req2), .imem_addr(addr2),
        .imem_ack(imem_ack), .imem_data(imem_data), .instr_valid(v2),
        .instr(instr2), .instr_pc(ipc2), .stall(stall), .redirect(redirect),
        .redirect_offset(redirect_offset), .halt(halt), .halted(halted2),
        .fetch_err(err2)
    );

    typedef struct {
        logic        ack;
        logic [31:0] data;
        logic        stall;
        logic        redir;
        logic [25:0] off;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] ipc;
        logic        err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic ack, input logic [31:0] data,
                                input logic stl, input logic rd, input logic [25:0] off,
                                input logic rq, input logic [31:0] ad, input logic vl,
                                input logic [31:0] ins, input logic [31:0] ip, input logic er);
        vec_t v;
        v.ack = ack; v.data = data; v.stall = stl; v.redir = rd; v.off = off;
        v.req = rq; v.addr = ad; v.valid = vl; v.instr = ins; v.ipc = ip; v.err = er;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        imem_ack = 1'b0; imem_data = 32'd0; stall = 1'b0;
        redirect = 1'b0; redirect_offset = 26'd0; halt = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " req"},    {31'd0, req1},    32'd0);
        chk({tag, " addr"},   addr1,            32'd0);
        chk({tag, " valid"},  {31'd0, v1},      32'd0);
        chk({tag, " instr"},  instr1,           32'd0);
        chk({tag, " ipc"},    ipc1,             32'd0);
        chk({tag, " halted"}, {31'd0, halted1}, 32'd0);
        chk({tag, " err"},    {31'd0, err1},    32'd0);
        chk({tag, " w.req"},  {31'd0, req2},    32'd0);
        chk({tag, " w.addr"}, addr2,            32'hFFFF_FFFC);
        chk({tag, " w.valid"},{31'd0, v2},      32'd0);
        chk({tag, " w.ipc"},  ipc2,             32'd0);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        chk_reset("reset");
        rst = 1'b0;

        //        ack data          stl rd off      req addr  v  instr         ipc   err
        tbl.push_back(mk(0, 32'h0,        0, 0, 26'h0,  0, 32'h00, 0, 32'h0,        32'h00, 0));
        tbl.push_back(mk(1, 32'hA000_0000, 0, 0, 26'h0,  1, 32'h00, 0, 32'h0,        32'h00, 0));
        tbl.push_back(mk(0, 32'h0,        0, 0, 26'h0,  0, 32'h04, 1, 32'hA000_0000, 32'h00, 0));
        tbl.push_back(mk(1, 32'hA000_0004, 0, 0, 26'h0,  1, 32'h04, 0, 32'hA000_0000, 32'h00, 0));
        tbl.push_back(mk(0, 32'h0,        0, 0, 26'h0,  0, 32'h08, 1, 32'hA000_0004, 32'h04, 0));
        tbl.push_back(mk(1, 32'hA000_0008, 0, 0, 26'h0,  1, 32'h08, 0, 32'hA000_0004, 32'h04, 0));
        tbl.push_back(mk(0, 32'h0,        0, 0, 26'h0,  0, 32'h0C, 1, 32'hA000_0008, 32'h08, 0));
        tbl.push_back(mk(1, 32'hA000_000C, 0, 0, 26'h0,  1, 32'h0C, 0, 32'hA000_0008, 32'h08, 0));
        // stall held three cycles, released on the fourth
        tbl.push_back(mk(0, 32'h0,        1, 0, 26'h0,  0, 32'h10, 1, 32'hA000_000C, 32'h0C, 0));
        tbl.push_back(mk(0, 32'h0,        1, 0, 26'h0,  0, 32'h10, 1, 32'hA000_000C, 32'h0C, 0));
        tbl.push_back(mk(0, 32'h0,        1, 0, 26'h0,  0, 32'h10, 1, 32'hA000_000C, 32'h0C, 0));
        tbl.push_back(mk(0, 32'h0,        0, 0, 26'h0,  0, 32'h10, 1, 32'hA000_000C, 32'h0C, 0));
        tbl.push_back(mk(1, 32'hA000_0010, 0, 0, 26'h0,  1, 32'h10, 0, 32'hA000_000C, 32'h0C, 0));
        // redirect in ISSUE, then redirect + ack in FETCH (ack data dropped)
        tbl.push_back(mk(0, 32'h0,        0, 1, 26'h10, 0, 32'h14, 1, 32'hA000_0010, 32'h10, 0));
        tbl.push_back(mk(1, 32'hDEAD_BEEF, 0, 1, 26'h20, 1, 32'h40, 0, 32'hA000_0010, 32'h10, 0));
        tbl.push_back(mk(1, 32'hA000_0080, 0, 0, 26'h0,  1, 32'h80, 0, 32'hA000_0010, 32'h10, 0));
        tbl.push_back(mk(0, 32'h0,        0, 0, 26'h0,  0, 32'h84, 1, 32'hA000_0080, 32'h80, 0));
        // ack on the 4th wait cycle: normal instruction, no error
        tbl.push_back(mk(0, 32'h0,        0, 0, 26'h0,  1, 32'h84, 0, 32'hA000_0080, 32'h80, 0));
        tbl.push_back(mk(0, 32'h0,        0, 0, 26'h0,  1, 32'h84, 0, 32'hA000_0080, 32'h80, 0));
        tbl.push_back(mk(0, 32'h0,        0, 0, 26'h0,  1, 32'h84, 0, 32'hA000_0080, 32'h80, 0));
        tbl.push_back(mk(1, 32'hA000_0084, 0, 0, 26'h0,  1, 32'h84, 0, 32'hA000_0080, 32'h80, 0));
        tbl.push_back(mk(0, 32'h0,        0, 0, 26'h0,  0, 32'h88, 1, 32'hA000_0084, 32'h84, 0));
        // no ack for 4 FETCH cycles: ERR
        tbl.push_back(mk(0, 32'h0,        0, 0, 26'h0,  1, 32'h88, 0, 32'hA000_0084, 32'h84, 0));
        tbl.push_back(mk(0, 32'h0,        0, 0, 26'h0,  1, 32'h88, 0, 32'hA000_0084, 32'h84, 0));
        tbl.push_back(mk(0, 32'h0,        0, 0, 26'h0,  1, 32'h88, 0, 32'hA000_0084, 32'h84, 0));
        tbl.push_back(mk(0, 32'h0,        0, 0, 26'h0,  1, 32'h88, 0, 32'hA000_0084, 32'h84, 0));
        tbl.push_back(mk(0, 32'h0,        0, 0, 26'h0,  0, 32'h88, 0, 32'hA000_0084, 32'h84, 1));
        tbl.push_back(mk(1, 32'hDEAD_BEEF, 0, 1, 26'h5,  0, 32'h88, 0, 32'hA000_0084, 32'h84, 1));
        tbl.push_back(mk(0, 32'h0,        0, 0, 26'h0,  0, 32'h88, 0, 32'hA000_0084, 32'h84, 1));

        foreach (tbl[i]) begin
            imem_ack = tbl[i].ack; imem_data = tbl[i].data; stall = tbl[i].stall;
            redirect = tbl[i].redir; redirect_offset = tbl[i].off; halt = 1'b0;
            chk($sformatf("c%0d req", i),    {31'd0, req1},    {31'd0, tbl[i].req});
            chk($sformatf("c%0d addr", i),   addr1,            tbl[i].addr);
            chk($sformatf("c%0d valid", i),  {31'd0, v1},      {31'd0, tbl[i].valid});
            chk($sformatf("c%0d instr", i),  instr1,           tbl[i].instr);
            chk($sformatf("c%0d ipc", i),    ipc1,             tbl[i].ipc);
            chk($sformatf("c%0d err", i),    {31'd0, err1},    {31'd0, tbl[i].err});
            chk($sformatf("c%0d halted", i), {31'd0, halted1}, 32'd0);
            tick();
        end

        // reset out of ERR, then PC wrap on the high-RESET_PC instance, then reset mid-wait
        idle_inputs();
        rst = 1'b1;
        tick();
        chk_reset("rst from err");
        rst = 1'b0;
        tick();
        imem_ack = 1'b1; imem_data = 32'h1234_5678;
        chk("wrap req", {31'd0, req2}, 32'd1);
        chk("wrap addr", addr2, 32'hFFFF_FFFC);
        tick();
        imem_ack = 1'b0;
        chk("wrap valid", {31'd0, v2}, 32'd1);
        chk("wrap ipc", ipc2, 32'hFFFF_FFFC);
        chk("wrap instr", instr2, 32'h1234_5678);
        chk("wrap next pc", addr2, 32'd0);
        chk("pc4 addr", addr1, 32'd4);
        tick();
        chk("wrap fetch addr", addr2, 32'd0);
        tick();
        chk("wait req", {31'd0, req1}, 32'd1);
        rst = 1'b1;
        tick();
        chk_reset("rst mid-wait");

        // halt while stalled in ISSUE
        rst = 1'b0;
        tick();
        imem_ack = 1'b1; imem_data = 32'h0000_0055;
        tick();
        imem_ack = 1'b0; stall = 1'b1; halt = 1'b1;
        chk("hs valid", {31'd0, v1}, 32'd1);
        chk("hs instr", instr1, 32'h0000_0055);
        tick();
        halt = 1'b0;
        chk("hs stalled valid", {31'd0, v1}, 32'd1);
        chk("hs stalled halted", {31'd0, halted1}, 32'd0);
        chk("hs stalled req", {31'd0, req1}, 32'd0);
        tick();
        stall = 1'b0;
        tick();
        chk("hs halted", {31'd0, halted1}, 32'd1);
        chk("hs valid off", {31'd0, v1}, 32'd0);
        chk("hs req", {31'd0, req1}, 32'd0);
        chk("hs addr", addr1, 32'd4);
        tick();
        chk("hs halted stays", {31'd0, halted1}, 32'd1);
        chk("hs req stays", {31'd0, req1}, 32'd0);

        // halt + redirect together in ISSUE
        do_reset();
        tick();
        imem_ack = 1'b1; imem_data = 32'h0000_0066;
        tick();
        imem_ack = 1'b0; redirect = 1'b1; redirect_offset = 26'h3; halt = 1'b1; stall = 1'b1;
        tick();
        idle_inputs();
        chk("hr halted", {31'd0, halted1}, 32'd1);
        chk("hr pc", addr1, 32'h0000_000C);
        chk("hr req", {31'd0, req1}, 32'd0);
        chk("hr valid", {31'd0, v1}, 32'd0);

        // halt beats a same-cycle ack in FETCH
        do_reset();
        tick();
        imem_ack = 1'b1; imem_data = 32'h0000_0077; halt = 1'b1;
        tick();
        idle_inputs();
        chk("hf halted", {31'd0, halted1}, 32'd1);
        chk("hf req", {31'd0, req1}, 32'd0);
        chk("hf valid", {31'd0, v1}, 32'd0);
        chk("hf instr", instr1, 32'd0);
        chk("hf pc", addr1, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Sequencing controller for the KGP-RISC instruction-fetch stage. It owns the program counter and issues word fetches to instruction memory over a req/ack handshake. It presents each fetched instruction to decode with a valid/stall handshake and applies branch redirects and flushes. It also handles halt requests, and detects an unresponsive memory with a bounded wait timeout.

## Interface
Parameters:
- RESET_PC, 32'd0, PC value loaded by reset.
- IMEM_TIMEOUT, 15, max consecutive FETCH cycles without imem_ack before error; legal range 1–255.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; high only in FETCH.
- imem_addr  out  32  fetch address; equals pc.
- imem_ack  in  1  memory returns imem_data this cycle for current imem_addr.
- imem_data  in  32  instruction word; sampled only when imem_req && imem_ack.
- instr_valid  out  1  instr/instr_pc hold a valid instruction for decode.
- instr  out  32  fetched instruction.
- instr_pc  out  32  address of instr.
- stall  in  1  decode not ready; instruction not consumed this cycle.
- redirect  in  1  branch taken; flush and refetch from target.
- redirect_offset  in  26  word offset; target = {4'b0, redirect_offset, 2'b00}.
- halt  in  1  stop fetching; sticky until rst.
- halted  out  1  block is in HALT.
- fetch_err  out  1  memory timeout occurred; sticky until rst.

## Operation
- States: IDLE, FETCH, ISSUE, HALT, ERR.
- Reset values:
  - state=IDLE, pc=RESET_PC.
  - instr_valid=0, instr=0, instr_pc=0.
  - halt_pending=0, wait_cnt=0.
  - halted=0, fetch_err=0, imem_req=0.
- IDLE → FETCH unconditionally.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ack: instr←imem_data, instr_pc←pc, instr_valid←1, pc←pc+4, → ISSUE.
  - Without ack: wait_cnt increments. When wait_cnt == IMEM_TIMEOUT-1 with no ack → ERR.
  - wait_cnt clears on every FETCH entry.
- ISSUE:
  - instr_valid=1 while stall=1; outputs held stable.
  - On stall=0 the instruction is consumed: instr_valid←0, then → HALT if halt_pending, else → FETCH.
- HALT: halted=1, imem_req=0, instr_valid=0. Exit only by rst.
- ERR: fetch_err=1, imem_req=0, instr_valid=0. Exit only by rst.
- halt sets halt_pending in any state. In FETCH, halt or halt_pending (without redirect) → HALT immediately and drops the request.
- Redirect (FETCH or ISSUE only; ignored in IDLE, HALT, ERR):
  - pc←target, instr_valid←0.
  - Any same-cycle ack data is discarded.
  - next state HALT if halt or halt_pending, else FETCH.
- Priority: rst > redirect > halt/halt_pending > imem_ack > stall.
- Memory may see imem_req/imem_addr withdrawn or changed in any cycle; a withdrawn request is abandoned and never retried.
- Arithmetic: pc+4 wraps modulo 2^32. pc is always word-aligned: RESET_PC[1:0] must be 0, and target[1:0]=0 by construction.

## Timing
- Zero-wait memory (ack in the request cycle): rst release → IDLE (cycle 0), FETCH with ack (cycle 1), instr_valid=1 in cycle 2.
- Steady-state throughput is one instruction per 2 cycles with no stall; each wait cycle adds 1.
- instr_valid, instr, instr_pc, halted and fetch_err are registered outputs.
- imem_req and imem_addr are decoded from state and pc.
- A redirect sampled in cycle n drives imem_addr=target in cycle n+1; the first redirected instruction is valid in cycle n+2 with a zero-wait memory.
- Timeout: with no ack, ERR is entered at the clock edge ending the IMEM_TIMEOUT-th FETCH cycle. An ack in that final cycle wins and no error is raised.
- rst mid-fetch or mid-issue aborts immediately; the next cycle shows all reset values.

## Structure
- Shared package/include kgp_fetch_pkg holds:
  - state encodings (3-bit);
  - PC_STEP=32'd4;
  - the target-formation function/macro ({4'b0, off, 2'b00}), reused by the branch unit.
- One natural sub-module: fetch_timeout_ctr.
  - Inputs: clr, en.
  - Output: expired.
  - Width $clog2(IMEM_TIMEOUT+1).
- FSM, PC register and output registers stay in fetch_sequencer.

## Test plan
- Reset, zero-wait memory, stall=0, RESET_PC=0: imem_addr sequence 0,4,8,12 in cycles 1,3,5,7. instr_valid pulses in cycles 2,4,6,8 with instr_pc matching.
- Stall held 3 cycles in ISSUE: instr/instr_pc stable, no imem_req during stall. The next fetch starts the cycle after stall drops.
- Redirect with offset 26'h10 while in ISSUE at pc=8: instr_valid drops the next cycle and imem_addr=32'h40. Same-cycle redirect+ack in FETCH: ack data never appears on instr.
- Memory never acks, IMEM_TIMEOUT=4: ERR entered after 4 FETCH cycles, fetch_err=1, imem_req=0. It stays there until rst. Ack on the 4th cycle produces a normal instruction and no error.
- halt asserted while stalled in ISSUE: halted=1 the cycle after stall drops, with no further imem_req. halt+redirect together: pc=target and halted=1.
- rst pulsed mid-wait and at pc=32'hFFFF_FFFC: all outputs return to reset values. Wrap check: pc+4 from FFFF_FFFC gives 0.
